// File: rtl/rs232_tx_fifo_if.sv
// Write-side bundle of the buffered RS232 transmitter: character strobe/data
// towards the FIFO and occupancy status back to the producer.
interface rs232_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          wr_en;
    logic [DATA_BITS-1:0]          wr_data;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   count;

    modport master (output wr_en, output wr_data, input full, input empty, input count);
    modport slave  (input wr_en, input wr_data, output full, output empty, output count);
endinterface

// File: rtl/rs232_tx_fifo.sv
// Buffered RS232 transmitter: characters queue in a small FIFO and are sent as
// start / LSB-first data / optional parity / stop frames on a registered TX line.
module rs232_tx_fifo #(
    parameter int CLKSPD     = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    rs232_tx_fifo_if.slave  wif,
    output logic            TX,
    output logic            busy,
    output logic            SentCLK
);
    localparam int DIV = CLKSPD / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CNW = PW + 1;
    localparam int BW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 sent_q, sent_d;
    logic                 busy_q, busy_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNW-1:0]       count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic                 wr_acc_s;
    logic                 pop_s;
    logic                 bound_s;
    logic [DATA_BITS-1:0] head_s;

    // Line value of the parity bit: 1 when the data ones-count needs padding.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        case (PARITY)
            1:       return ~(^d);
            2:       return ^d;
            default: return 1'b0;
        endcase
    endfunction

    assign head_s  = mem_q[rd_ptr_q];
    assign bound_s = (baud_q == CW'(DIV - 1));

    // FIFO pointer and occupancy update; full is judged before the edge.
    always_comb begin
        wr_acc_s = wif.wr_en & ~full_q;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc_s, pop_s})
            2'b10:   count_d = count_q + CNW'(1);
            2'b01:   count_d = count_q - CNW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNW'(FIFO_DEPTH));
        empty_d = (count_d == CNW'(0));
    end

    // Frame sequencer: next state, bit timing, pop request and next line value.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        sent_d  = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = CW'(0);
                bit_d  = BW'(0);
                if (!empty_q) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    par_d   = parity_bit(head_s);
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bound_s) begin
                    baud_d  = CW'(0);
                    bit_d   = BW'(0);
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (bound_s) begin
                    baud_d  = CW'(0);
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = BW'(0);
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            PAR: begin
                if (bound_s) begin
                    baud_d  = CW'(0);
                    bit_d   = BW'(0);
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (bound_s) begin
                    baud_d = CW'(0);
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        bit_d  = BW'(0);
                        sent_d = 1'b1;
                        // Chain straight into the next frame with no idle gap.
                        if (!empty_q) begin
                            pop_s   = 1'b1;
                            shift_d = head_s;
                            par_d   = parity_bit(head_s);
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = CW'(0);
                bit_d   = BW'(0);
            end
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PAR:     tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, timing, FIFO control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= CW'(0);
            bit_q    <= BW'(0);
            shift_q  <= {DATA_BITS{1'b0}};
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            sent_q   <= 1'b0;
            busy_q   <= 1'b0;
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CNW'(0);
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            sent_q   <= sent_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Character storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= wif.wr_data;
        end
    end

    assign TX        = tx_q;
    assign busy      = busy_q;
    assign SentCLK   = sent_q;
    assign wif.full  = full_q;
    assign wif.empty = empty_q;
    assign wif.count = count_q;
endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Directed bench for rs232_tx_fifo: three instances (no parity / even+2 stop /
// odd parity) checked cycle by cycle against a queue of expected characters.
module tb_rs232_tx_fifo;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs232_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if0 ();
    rs232_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if1 ();
    rs232_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if2 ();

    logic tx0, tx1, tx2, busy0, busy1, busy2, sent0, sent1, sent2;

    rs232_tx_fifo #(.CLKSPD(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut0 (.clk(clk), .rst(rst), .wif(if0), .TX(tx0), .busy(busy0), .SentCLK(sent0));
    rs232_tx_fifo #(.CLKSPD(1000), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16))
        dut1 (.clk(clk), .rst(rst), .wif(if1), .TX(tx1), .busy(busy1), .SentCLK(sent1));
    rs232_tx_fifo #(.CLKSPD(1000), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16))
        dut2 (.clk(clk), .rst(rst), .wif(if2), .TX(tx2), .busy(busy2), .SentCLK(sent2));

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];
    logic [7:0] sb2 [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int s);
        case (s)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_busy(input int s);
        case (s)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_sent(input int s);
        case (s)
            0:       return sent0;
            1:       return sent1;
            default: return sent2;
        endcase
    endfunction

    function automatic logic [31:0] get_count(input int s);
        case (s)
            0:       return 32'(if0.count);
            1:       return 32'(if1.count);
            default: return 32'(if2.count);
        endcase
    endfunction

    // One write strobe for one clock; expectation queued only if it should be accepted.
    task automatic wr(input int s, input logic [7:0] d, input bit acc);
        case (s)
            0:       begin if0.wr_en = 1'b1; if0.wr_data = d; if (acc) sb0.push_back(d); end
            1:       begin if1.wr_en = 1'b1; if1.wr_data = d; if (acc) sb1.push_back(d); end
            default: begin if2.wr_en = 1'b1; if2.wr_data = d; if (acc) sb2.push_back(d); end
        endcase
        step();
        if0.wr_en = 1'b0; if1.wr_en = 1'b0; if2.wr_en = 1'b0;
        if0.wr_data = ~d; if1.wr_data = ~d; if2.wr_data = ~d;
    endtask

    // Checks one frame; the current observation is cycle k0 after the start edge
    // (k0 = 0: wait for the start bit, which must appear after exp_wait cycles).
    task automatic rx_frame(input int s, input int k0, input int exp_wait);
        logic [7:0] d;
        logic       exp_tx;
        int par, nstop, len, waited, bitn, ones;
        par   = (s == 0) ? 0 : ((s == 1) ? 2 : 1);
        nstop = (s == 1) ? 2 : 1;
        len   = (1 + 8 + ((par != 0) ? 1 : 0) + nstop) * DIV;
        d     = 8'h00;
        checks++;
        case (s)
            0:       begin assert (sb0.size() > 0) else begin failures++; $error("FAIL sb_empty s=%0d", s); end
                           if (sb0.size() > 0) d = sb0.pop_front(); end
            1:       begin assert (sb1.size() > 0) else begin failures++; $error("FAIL sb_empty s=%0d", s); end
                           if (sb1.size() > 0) d = sb1.pop_front(); end
            default: begin assert (sb2.size() > 0) else begin failures++; $error("FAIL sb_empty s=%0d", s); end
                           if (sb2.size() > 0) d = sb2.pop_front(); end
        endcase
        ones = $countones(d);
        if (k0 == 0) begin
            waited = 0;
            while (get_tx(s) !== 1'b0 && waited < 30) begin
                step();
                waited++;
            end
            chk($sformatf("start_latency_s%0d", s), waited, exp_wait);
        end
        for (int k = k0; k <= len; k++) begin
            if (k == len) begin
                chk($sformatf("sent_pulse_s%0d", s), get_sent(s), 1'b1);
                break;
            end
            bitn = k / DIV;
            if (bitn == 0)                       exp_tx = 1'b0;
            else if (bitn <= 8)                  exp_tx = d[bitn-1];
            else if (par != 0 && bitn == 9)      exp_tx = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            else                                 exp_tx = 1'b1;
            chk($sformatf("tx_s%0d_d%0h_k%0d", s, d, k), get_tx(s), exp_tx);
            chk($sformatf("busy_s%0d_k%0d", s, k), get_busy(s), 1'b1);
            if (k > 0) chk($sformatf("sent_low_s%0d_k%0d", s, k), get_sent(s), 1'b0);
            step();
        end
    endtask

    int bad;

    initial begin
        if0.wr_en = 1'b0; if0.wr_data = 8'h00;
        if1.wr_en = 1'b0; if1.wr_data = 8'h00;
        if2.wr_en = 1'b0; if2.wr_data = 8'h00;

        // Reset and idle line
        rst = 1'b1;
        repeat (3) step();
        chk("rst_tx",    tx0, 1'b1);
        chk("rst_busy",  busy0, 1'b0);
        chk("rst_sent",  sent0, 1'b0);
        chk("rst_full",  if0.full, 1'b0);
        chk("rst_empty", if0.empty, 1'b1);
        chk("rst_count", get_count(0), 0);
        chk("rst_tx1",   tx1, 1'b1);
        chk("rst_tx2",   tx2, 1'b1);
        rst = 1'b0;
        bad = 0;
        repeat (200) begin
            step();
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || if0.empty !== 1'b1 || if0.count !== 3'd0 || sent0 !== 1'b0) bad++;
        end
        chk("idle_200_bad_cycles", bad, 0);

        // Single frame
        wr(0, 8'h55, 1'b1);
        chk("single_count", get_count(0), 1);
        chk("single_empty", if0.empty, 1'b0);
        chk("single_tx_before_pop", tx0, 1'b1);
        rx_frame(0, 0, 1);
        chk("single_end_busy",  busy0, 1'b0);
        chk("single_end_tx",    tx0, 1'b1);
        chk("single_end_empty", if0.empty, 1'b1);

        // Back-to-back: second write coincides with the first pop
        wr(0, 8'h41, 1'b1);
        chk("b2b_count_1", get_count(0), 1);
        chk("b2b_tx_idle", tx0, 1'b1);
        wr(0, 8'h42, 1'b1);
        chk("b2b_count_2", get_count(0), 1);
        chk("b2b_tx_start", tx0, 1'b0);
        wr(0, 8'h43, 1'b1);
        chk("b2b_count_3", get_count(0), 2);
        rx_frame(0, 1, 0);
        chk("b2b_count_pop2", get_count(0), 1);
        rx_frame(0, 0, 0);
        chk("b2b_count_pop3", get_count(0), 0);
        rx_frame(0, 0, 0);
        chk("b2b_end_busy", busy0, 1'b0);

        // Overflow on the 4-deep FIFO
        wr(0, 8'hA0, 1'b1); chk("ovf_count_a0", get_count(0), 1);
        wr(0, 8'hA1, 1'b1); chk("ovf_count_a1", get_count(0), 1);
        wr(0, 8'hA2, 1'b1); chk("ovf_count_a2", get_count(0), 2);
        wr(0, 8'hA3, 1'b1); chk("ovf_count_a3", get_count(0), 3);
        chk("ovf_not_full", if0.full, 1'b0);
        wr(0, 8'hA4, 1'b1); chk("ovf_count_a4", get_count(0), 4);
        chk("ovf_full", if0.full, 1'b1);
        wr(0, 8'hA5, 1'b0); chk("ovf_count_drop", get_count(0), 4);
        chk("ovf_full_held", if0.full, 1'b1);
        rx_frame(0, 4, 0);
        chk("ovf_count_f1", get_count(0), 3);
        chk("ovf_full_clear", if0.full, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rx_frame(0, 0, 0);
            chk($sformatf("ovf_count_f%0d", i + 2), get_count(0), (i < 3) ? (2 - i) : 0);
        end
        chk("ovf_end_busy", busy0, 1'b0);
        bad = 0;
        repeat (150) begin
            step();
            if (tx0 !== 1'b1 || sent0 !== 1'b0) bad++;
        end
        chk("ovf_no_sixth_frame", bad, 0);
        chk("ovf_sb_drained", sb0.size(), 0);

        // Parity and two stop bits
        wr(1, 8'h07, 1'b1);
        rx_frame(1, 0, 1);
        chk("even_end_busy", busy1, 1'b0);
        wr(1, 8'hA3, 1'b1);
        rx_frame(1, 0, 1);
        wr(2, 8'h07, 1'b1);
        rx_frame(2, 0, 1);
        chk("odd_end_busy", busy2, 1'b0);

        // Reset during data bit 3 with two characters queued
        wr(0, 8'hC6, 1'b1);
        wr(0, 8'h3A, 1'b1);
        wr(0, 8'h5C, 1'b1);
        repeat (44) step();
        chk("mid_pre_tx_bit3", tx0, 1'b0);
        chk("mid_pre_busy", busy0, 1'b1);
        chk("mid_pre_count", get_count(0), 2);
        rst = 1'b1;
        step();
        chk("mid_rst_tx",    tx0, 1'b1);
        chk("mid_rst_busy",  busy0, 1'b0);
        chk("mid_rst_count", get_count(0), 0);
        chk("mid_rst_empty", if0.empty, 1'b1);
        chk("mid_rst_sent",  sent0, 1'b0);
        rst = 1'b0;
        sb0.delete();
        bad = 0;
        repeat (300) begin
            step();
            if (tx0 !== 1'b1 || sent0 !== 1'b0 || busy0 !== 1'b0) bad++;
        end
        chk("mid_no_more_frames", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
